// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and sizes for the memory port arbiter
// Widths follow MEM_ADDR_SIZE / MEM_BANDWIDTH when the surrounding build defines them.
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 16
`endif

`ifndef MEM_BANDWIDTH
`define MEM_BANDWIDTH 4
`endif

package mem_port_arbiter_pkg;

  localparam int MEM_ADDR_W = `MEM_ADDR_SIZE;
  localparam int MEM_DATA_W = `MEM_BANDWIDTH * 8;

  localparam int MEM_NUM_REQ = 3;

  typedef enum logic [1:0] {
    REQ_IFMAP  = 2'd0,
    REQ_WEIGHT = 2'd1,
    REQ_COMP   = 2'd2
  } MEM_REQ_ID;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_RD_WAIT = 1'b1
  } MEM_ARB_STATE;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - client and memory-side signals of the memory port arbiter
// The slave modport is the arbiter's view; master is the clients-plus-memory view.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);
  logic              ifmap_req_valid;
  logic [ADDR_W-1:0] ifmap_req_addr;
  logic              ifmap_req_ready;
  logic [DATA_W-1:0] ifmap_rdata;
  logic              ifmap_rvalid;

  logic              weight_req_valid;
  logic [ADDR_W-1:0] weight_req_addr;
  logic              weight_req_ready;
  logic [DATA_W-1:0] weight_rdata;
  logic              weight_rvalid;

  logic              comp_wr_valid;
  logic [ADDR_W-1:0] comp_wr_addr;
  logic [DATA_W-1:0] comp_wr_data;
  logic              comp_wr_ready;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_valid;

  logic              busy;

  modport slave (
    input  ifmap_req_valid, ifmap_req_addr,
    output ifmap_req_ready, ifmap_rdata, ifmap_rvalid,
    input  weight_req_valid, weight_req_addr,
    output weight_req_ready, weight_rdata, weight_rvalid,
    input  comp_wr_valid, comp_wr_addr, comp_wr_data,
    output comp_wr_ready,
    output mem_addr, mem_write_data, mem_read, mem_write,
    input  mem_read_data, mem_valid,
    output busy
  );

  modport master (
    output ifmap_req_valid, ifmap_req_addr,
    input  ifmap_req_ready, ifmap_rdata, ifmap_rvalid,
    output weight_req_valid, weight_req_addr,
    input  weight_req_ready, weight_rdata, weight_rvalid,
    output comp_wr_valid, comp_wr_addr, comp_wr_data,
    input  comp_wr_ready,
    input  mem_addr, mem_write_data, mem_read, mem_write,
    output mem_read_data, mem_valid,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter3.sv
// rtl/mem_port_arbiter_rr_arbiter3.sv - combinational 3-way round-robin pick
// Search starts just after the last winner and wraps modulo 3.
module rr_arbiter3
  import mem_port_arbiter_pkg::*;
(
  input  logic [MEM_NUM_REQ-1:0] i_valid,
  input  logic [1:0]             i_rr_last,
  output logic [MEM_NUM_REQ-1:0] o_grant,
  output logic [1:0]             o_idx,
  output logic                   o_any
);
  logic [1:0] w_c0;
  logic [1:0] w_c1;
  logic [1:0] w_c2;

  assign w_c0  = rr_next(i_rr_last);
  assign w_c1  = rr_next(w_c0);
  assign w_c2  = rr_next(w_c1);
  assign o_any = |i_valid;

  always_comb begin
    o_grant = '0;
    o_idx   = 2'd0;
    if (i_valid[w_c0]) begin
      o_idx = w_c0;
    end else if (i_valid[w_c1]) begin
      o_idx = w_c1;
    end else if (i_valid[w_c2]) begin
      o_idx = w_c2;
    end
    if (o_any) begin
      o_grant[o_idx] = 1'b1;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin owner of the external memory port, one read in flight
// MEM_ARB_PERF_EN adds saturating grant/wait/stall counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
`ifdef MEM_ARB_PERF_EN
  , parameter int PERF_W = 32
`endif
)(
  input  logic clk,
  input  logic rst_n,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  , output logic [PERF_W-1:0] perf_grant_cnt [MEM_NUM_REQ],
  output logic [PERF_W-1:0] perf_wait_cnt,
  output logic [PERF_W-1:0] perf_stall_cnt
`endif
);
  MEM_ARB_STATE      r_state;
  MEM_ARB_STATE      w_state_nxt;
  logic [1:0]        r_rr_last;
  logic [1:0]        r_owner;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [DATA_W-1:0] r_ifmap_rdata;
  logic [DATA_W-1:0] r_weight_rdata;
  logic              r_ifmap_rvalid;
  logic              r_weight_rvalid;

  logic [MEM_NUM_REQ-1:0] w_valid;
  logic [MEM_NUM_REQ-1:0] w_grant;
  logic [MEM_NUM_REQ-1:0] w_ready;
  logic [1:0]             w_idx;
  logic                   w_any;
  logic                   w_xfer;
  logic                   w_rd_xfer;
  logic                   w_wr_xfer;
  logic                   w_rd_done;
  logic [ADDR_W-1:0]      w_rd_addr;

  assign w_valid = {bus.comp_wr_valid, bus.weight_req_valid, bus.ifmap_req_valid};

  rr_arbiter3 u_rr (
    .i_valid   (w_valid),
    .i_rr_last (r_rr_last),
    .o_grant   (w_grant),
    .o_idx     (w_idx),
    .o_any     (w_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The grant vector only ever selects a valid requester, so any valid in IDLE is a transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_xfer      = 1'b0;
    w_rd_done   = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_ready = w_grant;
        w_xfer  = w_any;
        if (w_any && (w_idx != REQ_COMP)) begin
          w_state_nxt = ARB_RD_WAIT;
        end
      end
      ARB_RD_WAIT: begin
        if (bus.mem_valid) begin
          w_rd_done   = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  assign w_rd_xfer = w_xfer && (w_idx != REQ_COMP);
  assign w_wr_xfer = w_xfer && (w_idx == REQ_COMP);
  assign w_rd_addr = (w_idx == REQ_WEIGHT) ? bus.weight_req_addr : bus.ifmap_req_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_last       <= 2'd2;
      r_owner         <= 2'd0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_ifmap_rdata   <= '0;
      r_weight_rdata  <= '0;
      r_ifmap_rvalid  <= 1'b0;
      r_weight_rvalid <= 1'b0;
    end else begin
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_ifmap_rvalid  <= 1'b0;
      r_weight_rvalid <= 1'b0;
      if (w_xfer) begin
        r_rr_last <= w_idx;
      end
      if (w_rd_xfer) begin
        r_mem_addr <= w_rd_addr;
        r_mem_read <= 1'b1;
        r_owner    <= w_idx;
      end
      if (w_wr_xfer) begin
        r_mem_addr  <= bus.comp_wr_addr;
        r_mem_wdata <= bus.comp_wr_data;
        r_mem_write <= 1'b1;
      end
      if (w_rd_done) begin
        if (r_owner == REQ_WEIGHT) begin
          r_weight_rdata  <= bus.mem_read_data;
          r_weight_rvalid <= 1'b1;
        end else begin
          r_ifmap_rdata  <= bus.mem_read_data;
          r_ifmap_rvalid <= 1'b1;
        end
      end
    end
  end

  assign bus.ifmap_req_ready  = w_ready[REQ_IFMAP];
  assign bus.weight_req_ready = w_ready[REQ_WEIGHT];
  assign bus.comp_wr_ready    = w_ready[REQ_COMP];
  assign bus.ifmap_rdata      = r_ifmap_rdata;
  assign bus.ifmap_rvalid     = r_ifmap_rvalid;
  assign bus.weight_rdata     = r_weight_rdata;
  assign bus.weight_rvalid    = r_weight_rvalid;
  assign bus.mem_addr         = r_mem_addr;
  assign bus.mem_write_data   = r_mem_wdata;
  assign bus.mem_read         = r_mem_read;
  assign bus.mem_write        = r_mem_write;
  assign bus.busy             = (r_state != ARB_IDLE) || w_any;

`ifdef MEM_ARB_PERF_EN
  logic [PERF_W-1:0] r_perf_grant [MEM_NUM_REQ];
  logic [PERF_W-1:0] r_perf_wait;
  logic [PERF_W-1:0] r_perf_stall;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  for (genvar g = 0; g < MEM_NUM_REQ; g++) begin : g_grant_cnt
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_perf_grant[g] <= '0;
      end else if (w_xfer && (w_idx == 2'(g))) begin
        r_perf_grant[g] <= sat_inc(r_perf_grant[g]);
      end
    end
    assign perf_grant_cnt[g] = r_perf_grant[g];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_wait  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (r_state == ARB_RD_WAIT) begin
        r_perf_wait <= sat_inc(r_perf_wait);
      end
      if (w_any && !w_xfer) begin
        r_perf_stall <= sat_inc(r_perf_stall);
      end
    end
  end

  assign perf_wait_cnt  = r_perf_wait;
  assign perf_stall_cnt = r_perf_stall;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
// Define MEM_ARB_PERF_EN to also check the performance counters.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_grant_cnt [3];
  logic [31:0] perf_wait_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MEM_ARB_PERF_EN
    , .perf_grant_cnt (perf_grant_cnt),
    .perf_wait_cnt  (perf_wait_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } mem_op_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } rsp_t;

  mem_op_t exp_mem[$];
  rsp_t    exp_rsp[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [1:0] m_rr_last;
  bit m_rd_pending;
  int mem_rem, mem_lat, cur_lat, rd_issue_cyc, sum_lat, stall_cycles, n_wr;
  int n_rsp[3];
  logic [AW-1:0] mem_rd_addr;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, ~a} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int exp_winner(input logic [2:0] v, input logic [1:0] last);
    int c = int'(last);
    for (int k = 0; k < 3; k++) begin
      c = (c + 1) % 3;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor plus memory model; called once per cycle at the negedge.
  task automatic mon_step();
    mem_op_t op;
    rsp_t    r;
    int      oi;
    if (bus.mem_read || bus.mem_write) begin
      chk("rw_exclusive", 64'(bus.mem_read & bus.mem_write), 64'd0);
      chk("mem_op_expected", 64'(exp_mem.size() > 0), 64'd1);
      if (exp_mem.size() > 0) begin
        op = exp_mem.pop_front();
        chk("op_write", 64'(bus.mem_write), 64'(op.wr));
        chk("op_read", 64'(bus.mem_read), 64'(!op.wr));
        chk("op_addr", 64'(bus.mem_addr), 64'(op.addr));
        chk("op_timing", 64'(cyc), 64'(op.cyc + 1));
        if (op.wr) begin
          chk("op_wdata", 64'(bus.mem_write_data), 64'(op.data));
          n_wr++;
        end
      end
      if (bus.mem_read) begin
        mem_rem      = mem_lat;
        cur_lat      = mem_lat;
        sum_lat     += mem_lat;
        rd_issue_cyc = cyc;
        mem_rd_addr  = bus.mem_addr;
      end
    end
    if (bus.ifmap_rvalid || bus.weight_rvalid) begin
      chk("rvalid_onehot", 64'(bus.ifmap_rvalid & bus.weight_rvalid), 64'd0);
      chk("rsp_expected", 64'(exp_rsp.size() > 0), 64'd1);
      if (exp_rsp.size() > 0) begin
        r  = exp_rsp.pop_front();
        oi = bus.weight_rvalid ? 1 : 0;
        chk("rsp_owner", 64'(oi), 64'(r.idx));
        chk("rsp_data", 64'(oi == 1 ? bus.weight_rdata : bus.ifmap_rdata), 64'(r.data));
        chk("rsp_latency", 64'(cyc), 64'(rd_issue_cyc + cur_lat));
        n_rsp[oi]++;
      end
      m_rd_pending = 1'b0;
    end
    bus.mem_valid     = 1'b0;
    bus.mem_read_data = $urandom();
    if (mem_rem > 0) begin
      mem_rem--;
      if (mem_rem == 0) begin
        bus.mem_valid     = 1'b1;
        bus.mem_read_data = mem_word(mem_rd_addr);
      end
    end
  endtask

  task automatic run_traffic(input int n0, input int n1, input int n2,
                             input int lat_lo, input int lat_hi, input int budget);
    int left[3];
    int sent[3];
    logic [2:0] v;
    logic [2:0] obs_rdy;
    logic [2:0] exp_rdy;
    logic [AW-1:0] a;
    int w;
    int t = 0;
    left = '{n0, n1, n2};
    sent = '{0, 0, 0};
    while ((left[0] + left[1] + left[2] > 0 || exp_mem.size() > 0 ||
            exp_rsp.size() > 0 || m_rd_pending) && t < budget) begin
      @(negedge clk);
      t++;
      mem_lat = $urandom_range(lat_hi, lat_lo);
      mon_step();
      v = {left[2] > 0, left[1] > 0, left[0] > 0};
      bus.ifmap_req_valid  = v[0];
      bus.ifmap_req_addr   = 16'h0010 + 16'(sent[0]);
      bus.weight_req_valid = v[1];
      bus.weight_req_addr  = 16'h0200 + 16'(sent[1]);
      bus.comp_wr_valid    = v[2];
      bus.comp_wr_addr     = 16'h0100 + 16'(sent[2]);
      bus.comp_wr_data     = {16'hC000 + 16'(sent[2]), 16'h0100 + 16'(sent[2])};
      #1;
      w = m_rd_pending ? -1 : exp_winner(v, m_rr_last);
      exp_rdy = (w < 0) ? 3'b000 : 3'(1 << w);
      obs_rdy = {bus.comp_wr_ready, bus.weight_req_ready, bus.ifmap_req_ready};
      chk("ready", 64'(obs_rdy), 64'(exp_rdy));
      chk("busy", 64'(bus.busy), 64'(m_rd_pending || (|v)));
      if (w >= 0) begin
        if (w == 2) begin
          exp_mem.push_back('{1'b1, bus.comp_wr_addr, bus.comp_wr_data, cyc});
        end else begin
          a = (w == 1) ? bus.weight_req_addr : bus.ifmap_req_addr;
          exp_mem.push_back('{1'b0, a, '0, cyc});
          exp_rsp.push_back('{w, mem_word(a)});
          m_rd_pending = 1'b1;
        end
        m_rr_last = 2'(w);
        left[w]--;
        sent[w]++;
      end else if (|v) begin
        stall_cycles++;
      end
    end
    bus.ifmap_req_valid  = 1'b0;
    bus.weight_req_valid = 1'b0;
    bus.comp_wr_valid    = 1'b0;
    chk("traffic_in_budget", 64'(t < budget), 64'd1);
  endtask

  task automatic model_clear();
    m_rr_last    = 2'd2;
    m_rd_pending = 1'b0;
    mem_rem      = 0;
    sum_lat      = 0;
    stall_cycles = 0;
    n_wr         = 0;
    n_rsp        = '{0, 0, 0};
    exp_mem.delete();
    exp_rsp.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.ifmap_req_valid  = 1'b0;
    bus.weight_req_valid = 1'b0;
    bus.comp_wr_valid    = 1'b0;
    bus.mem_valid        = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    bus.ifmap_req_valid  = 1'b0;
    bus.ifmap_req_addr   = '0;
    bus.weight_req_valid = 1'b0;
    bus.weight_req_addr  = '0;
    bus.comp_wr_valid    = 1'b0;
    bus.comp_wr_addr     = '0;
    bus.comp_wr_data     = '0;
    bus.mem_valid        = 1'b0;
    bus.mem_read_data    = '0;
    mem_lat              = 1;
    cur_lat              = 0;
    rd_issue_cyc         = 0;
    mem_rd_addr          = '0;
    do_reset();

    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_write_data), 64'd0);
    chk("rst_mem_read", 64'(bus.mem_read), 64'd0);
    chk("rst_mem_write", 64'(bus.mem_write), 64'd0);
    chk("rst_ifmap_rdata", 64'(bus.ifmap_rdata), 64'd0);
    chk("rst_weight_rdata", 64'(bus.weight_rdata), 64'd0);
    chk("rst_rvalids", 64'({bus.ifmap_rvalid, bus.weight_rvalid}), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);

    // single ifmap read, latency 3
    run_traffic(1, 0, 0, 3, 3, 50);
    chk("t1_ifmap_rsp", 64'(n_rsp[0]), 64'd1);
    chk("t1_weight_rsp", 64'(n_rsp[1]), 64'd0);

    // three-way contention from reset, 30 grants
    do_reset();
    run_traffic(10, 10, 10, 1, 4, 2000);
    chk("t2_ifmap_rsp", 64'(n_rsp[0]), 64'd10);
    chk("t2_weight_rsp", 64'(n_rsp[1]), 64'd10);
    chk("t2_writes", 64'(n_wr), 64'd10);
`ifdef MEM_ARB_PERF_EN
    chk("perf_grant_ifmap", 64'(perf_grant_cnt[0]), 64'd10);
    chk("perf_grant_weight", 64'(perf_grant_cnt[1]), 64'd10);
    chk("perf_grant_comp", 64'(perf_grant_cnt[2]), 64'd10);
    chk("perf_wait", 64'(perf_wait_cnt), 64'(sum_lat));
    chk("perf_stall", 64'(perf_stall_cnt), 64'(stall_cycles));
`endif

    // back-to-back writes 0x100..0x103
    n_wr = 0;
    run_traffic(0, 0, 4, 1, 1, 50);
    chk("t3_writes", 64'(n_wr), 64'd4);

    // a long weight read holds off the compressor
    n_wr = 0;
    n_rsp = '{0, 0, 0};
    run_traffic(0, 1, 1, 10, 10, 100);
    chk("t4_weight_rsp", 64'(n_rsp[1]), 64'd1);
    chk("t4_writes", 64'(n_wr), 64'd1);

    // reset while a read is outstanding, then a late mem_valid
    @(negedge clk);
    bus.ifmap_req_valid = 1'b1;
    bus.ifmap_req_addr  = 16'h0020;
    #1;
    chk("t5_ready", 64'(bus.ifmap_req_ready), 64'd1);
    @(negedge clk);
    bus.ifmap_req_valid = 1'b0;
    chk("t5_mem_read", 64'(bus.mem_read), 64'd1);
    chk("t5_mem_addr", 64'(bus.mem_addr), 64'h20);
    @(negedge clk);
    chk("t5_busy_wait", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_rst_mem_read", 64'(bus.mem_read), 64'd0);
    chk("t5_rst_idle", 64'(bus.busy), 64'd0);
    bus.mem_valid     = 1'b1;
    bus.mem_read_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    chk("t5_no_rvalid", 64'({bus.ifmap_rvalid, bus.weight_rvalid}), 64'd0);
    chk("t5_ifmap_rdata", 64'(bus.ifmap_rdata), 64'd0);
    @(negedge clk);
    chk("t5_no_rvalid_late", 64'({bus.ifmap_rvalid, bus.weight_rvalid}), 64'd0);
    chk("t5_still_idle", 64'(bus.busy), 64'd0);
    model_clear();

    // port recovers with ifmap priority restored
    run_traffic(1, 1, 1, 2, 2, 100);
    chk("t5_recover_rsp", 64'(n_rsp[0] + n_rsp[1]), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
